// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute controller driving the CPU datapath strobes.
// Define COND_JUMP_EN to enable JZ (6) / JC (7); otherwise they execute as NOP.
module instr_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       carry,
  input  logic       mem_rdy,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_ld,
  output logic       mar_sel,
  output logic       mem_rd,
  output logic       ir_ld,
  output logic       b_ld,
  output logic       acc_ld,
  output logic       out_ld,
  output logic       alu_sub,
  output logic       halted,
  output logic [2:0] tstate
);
  typedef enum logic [2:0] {IDLE, F1, F2, DEC, E1, E2, E3, HALT} state_t;
  state_t state, nxt, fin;
  logic [3:0] op;
  logic exec, mem_op;
`ifdef COND_JUMP_EN
  assign exec = opcode inside {[4'h1:4'h5]} || (opcode == 4'h6 && zero) || (opcode == 4'h7 && carry);
`else
  logic unused_flags;
  assign unused_flags = zero ^ carry;
  assign exec = opcode inside {[4'h1:4'h5]};
`endif
  assign mem_op = op inside {[4'h1:4'h3]};
  assign fin = run ? F1 : IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = run ? F1 : IDLE;
      F1:      nxt = F2;
      F2:      nxt = mem_rdy ? DEC : F2;
      DEC:     nxt = opcode == 4'hf ? HALT : exec ? E1 : fin;
      E1:      nxt = mem_op ? E2 : fin;
      E2:      nxt = !mem_rdy ? E2 : op == 4'h1 ? fin : E3;
      E3:      nxt = fin;
      default: nxt = HALT;
    endcase
  end
  // op holds the decoded opcode so the execute states need not rely on the IR staying put
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op    <= '0;
    end else begin
      state <= nxt;
      if (state == DEC) op <= opcode;
    end
  end
  assign pc_inc  = state == F2 && mem_rdy;
  assign ir_ld   = state == F2 && mem_rdy;
  assign pc_load = state == E1 && op inside {[4'h5:4'h7]};
  assign mar_sel = state == E1 && mem_op;
  assign mar_ld  = state == F1 || (state == E1 && mem_op);
  assign mem_rd  = state == F2 || state == E2;
  assign b_ld    = state == E2 && mem_rdy && op != 4'h1;
  assign acc_ld  = (state == E2 && mem_rdy && op == 4'h1) || state == E3;
  assign out_ld  = state == E1 && op == 4'h4;
  assign alu_sub = state == E3 && op == 4'h3;
  assign halted  = state == HALT;
  assign tstate  = state;
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction-cycle controller for the 8-bit CPU. It steps a fetch/decode/execute state machine and drives the control word for the 4-bit program counter (increment enable and parallel load), the memory address register, memory read, the instruction register, the accumulator/B registers and the output port. It sits between the instruction register's opcode nibble and every load/enable strobe in the datapath.

## Interface
- No parameters; opcode width 4, state code width 3.
- Clock  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high; forces IDLE.
- RUN  in  1  1 = sequence instructions; 0 = stop at next instruction boundary.
- OPCODE  in  4  IR upper nibble, valid from cycle after IR_LD.
- ZERO  in  1  accumulator zero flag.
- CARRY  in  1  ALU carry flag.
- MEM_RDY  in  1  memory read data valid this cycle.
- PC_INC  out  1  PC count enable (PCEN).
- PC_LOAD  out  1  PC parallel load from IR operand (LOAD).
- MAR_LD  out  1  load memory address register.
- MAR_SEL  out  1  MAR source: 0 = PC, 1 = IR operand.
- MEM_RD  out  1  memory read request.
- IR_LD, B_LD, ACC_LD, OUT_LD  out  1 each  register load strobes.
- ALU_SUB  out  1  ALU subtract select.
- HALTED  out  1  1 while in HALT.
- TSTATE  out  3  current state code.

## Operation
- States/codes: IDLE 0, F1 1, F2 2, DEC 3, E1 4, E2 5, E3 6, HALT 7.
- Outputs decoded combinationally from state register (and MEM_RDY/opcode/flags where noted); all unlisted outputs 0.
- IDLE: RUN=1 -> F1, else stay.
- F1: MAR_SEL=0, MAR_LD=1 -> F2.
- F2: MEM_RD=1; MEM_RDY=0 -> stay; MEM_RDY=1 -> IR_LD=1, PC_INC=1, -> DEC.
- DEC: opcode decode, ZERO/CARRY sampled here. 0 NOP, undefined opcodes -> instruction end; F HLT -> HALT; others -> E1.
- LDA (1): E1 MAR_SEL=1, MAR_LD=1; E2 MEM_RD=1, wait MEM_RDY, then ACC_LD=1 -> end.
- ADD (2)/SUB (3): E1 as LDA; E2 MEM_RD=1, wait, then B_LD=1; E3 ACC_LD=1, ALU_SUB=1 for SUB -> end.
- OUT (4): E1 OUT_LD=1 -> end.
- JMP (5): E1 PC_LOAD=1 -> end.
- JZ (6)/JC (7): see Configuration.
- Instruction end: RUN=1 -> F1, RUN=0 -> IDLE. RUN sampled only here and in IDLE.
- HALT: HALTED=1, all strobes 0; exits only via RESET.
- PC_INC and PC_LOAD never asserted in the same cycle.

## Timing
- RESET async: state IDLE, TSTATE=0, all outputs 0 within same cycle; deassertion synchronous to next edge.
- MEM_RDY tied 1: NOP/OUT/JMP taken = 3/4/4 cycles, LDA 5, ADD/SUB 6, HLT 3 to HALT.
- Each MEM_RDY=0 cycle in F2 or E2 adds exactly one cycle; strobes qualified by MEM_RDY fire only in the ready cycle.
- RESET mid-instruction: aborts immediately; no partial strobe after assertion.
- PC value advances on edge ending F2; PC_LOAD takes effect on edge ending E1.

## Configuration
- COND_JUMP_EN defined: JZ in E1 asserts PC_LOAD iff ZERO sampled 1 in DEC, JC likewise with CARRY; not-taken branch skips E1 (DEC -> end, 3 cycles).
- Undefined: opcodes 6/7 execute as NOP (3 cycles), ZERO/CARRY ignored.

## Test plan
- RESET=1 mid-E2 of ADD -> TSTATE=0, all strobes 0 same cycle; after release with RUN=1, F1 next.
- RUN=1, MEM_RDY=1, program LDA,ADD,OUT,HLT -> TSTATE sequence 1,2,3,4,5 / 1,2,3,4,5,6 / 1,2,3,4 / 1,2,3,7; HALTED=1 after 18 cycles.
- LDA with MEM_RDY low 2 cycles in F2 and 1 in E2 -> instruction takes 8 cycles; IR_LD and ACC_LD each pulse once.
- JMP -> single PC_LOAD pulse in E1, PC_INC only in F2; never both high.
- COND_JUMP_EN on, JZ with ZERO=1 -> PC_LOAD in E1 (4 cycles); ZERO=0 -> no PC_LOAD (3 cycles). Macro off -> 3 cycles, no PC_LOAD.
- RUN dropped during E1 of SUB -> SUB completes (ACC_LD, ALU_SUB in E3), then IDLE; no F1 until RUN=1.
